demux1_n_stream: RTL and testbench
==================================

DEMUX1_N_STREAM -- requirements
Module: demux1_n_stream

Interface
REQ-001 Parameter N_OUT, default 8: number of output channels, legal range 2..16.
REQ-002 Parameter DATA_W, default 8: payload width in bits, legal range 1..64.
REQ-003 Parameter SEL_W, default $clog2(N_OUT): select width, derived; the user shall not override it.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port in_data, input, DATA_W: input payload.
REQ-007 Port in_sel, input, SEL_W: destination channel, sampled on the first beat of a packet only.
REQ-008 Port in_last, input, 1: final beat of the packet.
REQ-009 Port in_valid, input, 1: input beat present.
REQ-010 Port in_ready, output, 1: block accepts the beat this cycle.
REQ-011 Port out_data, output, N_OUT*DATA_W: per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-012 Port out_last, output, N_OUT: per-channel last flag.
REQ-013 Port out_valid, output, N_OUT: per-channel beat present.
REQ-014 Port out_ready, input, N_OUT: per-channel sink accepts.
REQ-015 Port drop_pulse, output, 1: one-cycle pulse for each beat discarded due to an out-of-range select.

Function
REQ-016 Transfer rule: a beat moves when valid and ready are both high at the rising edge; valid, once high, shall not drop and data shall not change until the transfer completes.
REQ-017 Each channel holds a one-entry output register (data, last, valid).
REQ-018 Routing FSM states: IDLE (no packet open) and PKT (packet open, channel locked in cur_sel).
REQ-019 In IDLE, target = in_sel; in PKT, target = cur_sel; in_sel is ignored mid-packet.
REQ-020 Transitions: IDLE->PKT on an accepted beat with in_last=0, latching cur_sel=in_sel; PKT->IDLE on an accepted beat with in_last=1; an accepted single-beat packet (in_last=1) in IDLE stays in IDLE.
REQ-021 For an in-range target, in_ready = ~out_valid[target] | out_ready[target], combinational.
REQ-022 Latency: a beat accepted at edge k shall appear on out_valid/out_data/out_last of the target channel after edge k; back-to-back beats to one channel shall sustain one beat per cycle while out_ready is held high.
REQ-023 A channel register that empties and fills on the same edge shall stay valid and carry the new beat.
REQ-024 Out-of-range target (>= N_OUT, possible only when N_OUT is not a power of two): in_ready=1, the beat is discarded, drop_pulse=1 in the following cycle, and the FSM follows REQ-020 so the whole packet is discarded.
REQ-025 Channels are independent: a stalled channel shall not block draining of the other channels; it blocks input only while it is the target.
REQ-026 in_ready shall be 0 while rst_n is low.

Reset
REQ-027 Asserting rst_n low shall immediately clear the FSM to IDLE, cur_sel to 0, every out_valid to 0, out_last to 0, out_data to 0 and drop_pulse to 0; no re-arm cycle shall be needed after release.
REQ-028 Reset mid-packet shall lose the open packet silently; the first beat after release shall be treated as a packet start.

Configuration
REQ-029 Macro DEMUX_DROP_CNT_EN defined: add output drop_cnt (16 bits), a saturating count of discarded beats (holds at 0xFFFF), cleared by reset.
REQ-030 Macro DEMUX_DROP_CNT_EN undefined: drop_cnt port and its logic are absent; drop_pulse is unchanged.

Structure
REQ-031 Package demux_pkg shall hold the FSM state enum (ST_IDLE, ST_PKT) and the parameter range-limit constants.
REQ-032 Sub-module demux_chan_reg shall implement one channel's output register, instantiated N_OUT times by generate.

Verification
REQ-033 Reset, then N_OUT=8, DATA_W=8, single beats in_sel=0..7, data=0xA0+sel, last=1, out_ready all 1 -> each channel i gets exactly one beat 0xA0+i one cycle after acceptance.
REQ-034 4-beat packet, in_sel=3 on beat 0, in_sel changed to 5 on beats 1-3 -> all four beats on channel 3, none on channel 5, FSM back to IDLE after the last beat.
REQ-035 out_ready[2]=0 with channel 2 full and a new beat for channel 2 -> in_ready=0; a beat to channel 4 is still accepted and channel 2 data is held stable.
REQ-036 N_OUT=6, in_sel=7, 3-beat packet -> in_ready=1 throughout, no out_valid, three drop_pulse cycles; with DEMUX_DROP_CNT_EN, drop_cnt=3.
REQ-037 rst_n low after beat 2 of a 4-beat packet to channel 1 -> all outputs cleared asynchronously; the next beat after release with in_sel=6 routes to channel 6.
REQ-038 Continuous stream to channel 0 with out_ready toggling each cycle -> no beat lost or duplicated, order preserved, and the scoreboard matches.

Source files
------------

// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg -- shared types and constants for the 1:N stream demultiplexer.
//
// Contents:
//   state_e      routing FSM state (ST_IDLE: no packet open, ST_PKT: packet
//                open and its channel locked)
//   N_OUT_MIN/MAX, DATA_W_MIN/MAX   legal parameter ranges of demux1_n_stream
//   DROP_CNT_W   width of the optional discarded-beat counter
// ---------------------------------------------------------------------------
package demux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  localparam int N_OUT_MIN  = 2;
  localparam int N_OUT_MAX  = 16;
  localparam int DATA_W_MIN = 1;
  localparam int DATA_W_MAX = 64;

  localparam int DROP_CNT_W = 16;

endpackage : demux_pkg

// File: rtl/demux_chan_reg.sv
// ---------------------------------------------------------------------------
// demux_chan_reg -- one-entry output register for a single demux channel.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_i         write the beat on data_i/last_i this edge
//   data_i, last_i beat payload and end-of-packet flag
//   ready_i        downstream sink accepts the held beat
//   valid_o        register holds a beat
//   data_o, last_o held payload and end-of-packet flag
//   can_load_o     register is empty or drains this edge, so it can be loaded
// ---------------------------------------------------------------------------
module demux_chan_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              can_load_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  // A full register that drains on this edge can take a new beat on the same
  // edge, which is what keeps one beat per cycle flowing.
  assign can_load_o = ~valid_q | ready_i;

  // NOTE: the payload is reset as well as the valid bit because the outputs
  // are required to read zero during reset, not merely "don't care".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      // Load wins over drain: empty-and-fill on one edge stays valid.
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule : demux_chan_reg

// File: rtl/demux1_n_stream.sv
// ---------------------------------------------------------------------------
// demux1_n_stream -- packet-aware 1:N valid/ready stream demultiplexer.
//
// The channel is chosen by in_sel on the first beat of each packet and held
// until the beat carrying in_last. Each output channel has its own one-entry
// register, so a stalled channel only blocks input while it is the target.
// Packets addressed to a non-existent channel are swallowed whole, with one
// drop_pulse per discarded beat.
//
// Parameters: N_OUT (2..16) channels, DATA_W (1..64) payload bits,
//             SEL_W = $clog2(N_OUT) derived, not overridable.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_data/in_sel/in_last/in_valid, in_ready   input stream
//   out_data (channel i at [i*DATA_W +: DATA_W]), out_last, out_valid,
//   out_ready                    per-channel output streams
//   drop_pulse                   one cycle per discarded beat
//   drop_cnt  (only with DEMUX_DROP_CNT_EN)  saturating discarded-beat count
//
// Build option: define DEMUX_DROP_CNT_EN to add the drop_cnt output.
// ---------------------------------------------------------------------------
module demux1_n_stream
  import demux_pkg::*;
#(
  parameter  int N_OUT  = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    drop_pulse
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);

  // One wider than the select so N_OUT itself is representable.
  localparam logic [SEL_W:0] N_OUT_LIM = (SEL_W + 1)'(N_OUT);

  state_e           state_q;
  logic [SEL_W-1:0] cur_sel_q;
  logic             drop_pulse_q;

  logic [SEL_W-1:0] target;
  logic             in_range;
  logic             sel_ready;
  logic             accept;
  logic             drop_evt;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] chan_can_load;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    target    = (state_q == ST_PKT) ? cur_sel_q : in_sel;
    in_range  = ({1'b0, target} < N_OUT_LIM);
    sel_ready = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (target == SEL_W'(i)) sel_ready = chan_can_load[i];
    end
    // Out-of-range beats are always taken so the packet can be discarded;
    // nothing is taken while reset is asserted.
    in_ready = rst_n & (in_range ? sel_ready : 1'b1);
    accept   = in_valid & in_ready;
    drop_evt = accept & ~in_range;
    load     = '0;
    for (int i = 0; i < N_OUT; i++) begin
      load[i] = accept & (target == SEL_W'(i));
    end
  end

  // Routing FSM. A single-beat packet (in_last on the first beat) never
  // leaves ST_IDLE, so the next beat is again a packet start.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_sel_q    <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= drop_evt;
      if (accept) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!in_last) begin
              state_q   <= ST_PKT;
              cur_sel_q <= in_sel;
            end
          end
          ST_PKT: begin
            if (in_last) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign drop_pulse = drop_pulse_q;

  for (genvar g = 0; g < N_OUT; g++) begin : g_chan
    demux_chan_reg #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load[g]),
      .data_i     (in_data),
      .last_i     (in_last),
      .ready_i    (out_ready[g]),
      .valid_o    (out_valid[g]),
      .data_o     (out_data[g*DATA_W +: DATA_W]),
      .last_o     (out_last[g]),
      .can_load_o (chan_can_load[g])
    );
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;

  // Saturate at all-ones rather than wrapping back to zero.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_evt && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule : demux1_n_stream

// File: tb/tb_demux1_n_stream.sv
// ---------------------------------------------------------------------------
// tb_demux1_n_stream -- directed bench for demux1_n_stream.
// dut  : N_OUT=8, DATA_W=8 (power-of-two channel count)
// dut6 : N_OUT=6, DATA_W=8 (out-of-range selects possible)
// Build option: DEMUX_DROP_CNT_EN also checks drop_cnt.
// ---------------------------------------------------------------------------
module tb_demux1_n_stream;
  import demux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  in_data = '0;
  logic [2:0]  in_sel = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_last;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = 8'hFF;
  logic        drop_pulse;

  logic [7:0]  in6_data = '0;
  logic [2:0]  in6_sel = '0;
  logic        in6_last = 1'b0;
  logic        in6_valid = 1'b0;
  logic        in6_ready;
  logic [47:0] out6_data;
  logic [5:0]  out6_last;
  logic [5:0]  out6_valid;
  logic [5:0]  out6_ready = 6'h3F;
  logic        drop6_pulse;

`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic [15:0] drop6_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Received beats of dut in order: {channel[3:0], last, data[7:0]}.
  logic [12:0] rx_q[$];
  int          drop6_seen = 0;

  always #5 clk = ~clk;

  demux1_n_stream #(.N_OUT(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .drop_pulse(drop_pulse)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  demux1_n_stream #(.N_OUT(6), .DATA_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in6_data), .in_sel(in6_sel), .in_last(in6_last),
    .in_valid(in6_valid), .in_ready(in6_ready),
    .out_data(out6_data), .out_last(out6_last), .out_valid(out6_valid),
    .out_ready(out6_ready), .drop_pulse(drop6_pulse)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt(drop6_cnt)
`endif
  );

  // Output monitor: records every completed output transfer.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        if (out_valid[i] && out_ready[i])
          rx_q.push_back({4'(i), out_last[i], out_data[i*8 +: 8]});
      end
      if (drop6_pulse) drop6_seen++;
    end
  end

  // Presents one beat on dut and returns after the edge that accepted it
  // (#1 past that edge), leaving in_valid high. ok=0 if never accepted.
  task automatic send(input logic [2:0] sel, input logic [7:0] d,
                      input logic last, output bit ok);
    in_sel   = sel;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b0 || in6_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready, in6_ready);
    end
    checks++;
    if (out_valid !== 8'h00 || out_last !== 8'h00 || out_data !== 64'h0 ||
        drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%h last=%h data=%h drop=%b want all 0",
               out_valid, out_last, out_data, drop_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_beats();
    bit ok;
    rx_q.delete();
    for (int s = 0; s < 8; s++) begin
      send(3'(s), 8'hA0 + 8'(s), 1'b1, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL single_accept[%0d]: got timeout want accepted", s);
      end
      checks++;
      if (out_valid !== (8'h01 << s) || out_data[s*8 +: 8] !== 8'hA0 + 8'(s) ||
          out_last[s] !== 1'b1) begin
        errors++;
        $display("FAIL single_out[%0d]: valid=%h data=%h want valid=%h data=%h",
                 s, out_valid, out_data[s*8 +: 8], 8'h01 << s, 8'hA0 + 8'(s));
      end
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rx_q.size() != 8) begin
      errors++;
      $display("FAIL single_count: got %0d want 8", rx_q.size());
    end else begin
      for (int s = 0; s < 8; s++) begin
        checks++;
        if (rx_q[s] !== {4'(s), 1'b1, 8'hA0 + 8'(s)}) begin
          errors++;
          $display("FAIL single_rx[%0d]: got %h want %h", s, rx_q[s],
                   {4'(s), 1'b1, 8'hA0 + 8'(s)});
        end
      end
    end
  endtask

  task automatic test_packet_lock();
    bit ok;
    rx_q.delete();
    for (int b = 0; b < 4; b++) begin
      send((b == 0) ? 3'd3 : 3'd5, 8'h31 + 8'(b), (b == 3), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pkt_accept[%0d]: got timeout want accepted", b);
      end
      if (b == 0) begin
        checks++;
        if (dut.state_q !== ST_PKT) begin
          errors++;
          $display("FAIL pkt_state_open: got %0d want %0d", dut.state_q, ST_PKT);
        end
      end
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL pkt_state_close: got %0d want %0d", dut.state_q, ST_IDLE);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rx_q.size() != 4) begin
      errors++;
      $display("FAIL pkt_count: got %0d want 4", rx_q.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (rx_q[b] !== {4'd3, (b == 3), 8'h31 + 8'(b)}) begin
          errors++;
          $display("FAIL pkt_rx[%0d]: got %h want %h", b, rx_q[b],
                   {4'd3, (b == 3), 8'h31 + 8'(b)});
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    rx_q.delete();
    out_ready[2] = 1'b0;
    send(3'd2, 8'h22, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_fill: got timeout want accepted");
    end
    send(3'd4, 8'h44, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_other_chan: got timeout want accepted");
    end
    // A further beat for the stalled channel must be refused.
    in_sel = 3'd2; in_data = 8'h33; in_last = 1'b1; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: got %b want 0", in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h22) begin
      errors++;
      $display("FAIL stall_hold: ready=%b valid=%b data=%h want 0/1/22",
               in_ready, out_valid[2], out_data[23:16]);
    end
    out_ready[2] = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    // Drained and refilled on the same edge: still valid, new payload.
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h33) begin
      errors++;
      $display("FAIL stall_refill: valid=%b data=%h want 1/33",
               out_valid[2], out_data[23:16]);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rx_q.size() != 3 || rx_q[0] !== {4'd4, 1'b1, 8'h44} ||
        rx_q[1] !== {4'd2, 1'b1, 8'h22} || rx_q[2] !== {4'd2, 1'b1, 8'h33}) begin
      errors++;
      $display("FAIL stall_rx: got %0d beats want 3 (44,22,33)", rx_q.size());
    end
  endtask

  task automatic test_drop();
    drop6_seen = 0;
    for (int b = 0; b < 3; b++) begin
      in6_sel = (b == 0) ? 3'd7 : 3'd2;
      in6_data = 8'h70 + 8'(b);
      in6_last = (b == 2);
      in6_valid = 1'b1;
      #1;
      checks++;
      if (in6_ready !== 1'b1) begin
        errors++;
        $display("FAIL drop_ready[%0d]: got %b want 1", b, in6_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out6_valid !== 6'h00 || drop6_pulse !== 1'b1) begin
        errors++;
        $display("FAIL drop_beat[%0d]: valid=%h pulse=%b want 00/1",
                 b, out6_valid, drop6_pulse);
      end
    end
    in6_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (drop6_pulse !== 1'b0 || drop6_seen != 3 || out6_valid !== 6'h00) begin
      errors++;
      $display("FAIL drop_total: pulse=%b pulses=%0d valid=%h want 0/3/00",
               drop6_pulse, drop6_seen, out6_valid);
    end
    checks++;
    if (dut6.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL drop_state: got %0d want %0d", dut6.state_q, ST_IDLE);
    end
`ifdef DEMUX_DROP_CNT_EN
    checks++;
    if (drop6_cnt !== 16'd3) begin
      errors++;
      $display("FAIL drop_cnt: got %0d want 3", drop6_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    rx_q.delete();
    send(3'd1, 8'h51, 1'b0, ok);
    send(3'd1, 8'h52, 1'b0, ok);
    in_valid = 1'b0;
    checks++;
    if (!ok || out_valid[1] !== 1'b1 || dut.state_q !== ST_PKT) begin
      errors++;
      $display("FAIL mid_pre: ok=%b valid=%b state=%0d want 1/1/%0d",
               ok, out_valid[1], dut.state_q, ST_PKT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 8'h00 || out_last !== 8'h00 || out_data !== 64'h0 ||
        in_ready !== 1'b0 || drop_pulse !== 1'b0 || dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_async_clear: valid=%h data=%h ready=%b state=%0d want 0",
               out_valid, out_data, in_ready, dut.state_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3'd6, 8'h66, 1'b1, ok);
    in_valid = 1'b0;
    checks++;
    if (!ok || out_valid !== 8'h40 || out_data[55:48] !== 8'h66) begin
      errors++;
      $display("FAIL mid_restart: ok=%b valid=%h data=%h want 1/40/66",
               ok, out_valid, out_data[55:48]);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== {4'd1, 1'b0, 8'h51} ||
        rx_q[1] !== {4'd6, 1'b1, 8'h66}) begin
      errors++;
      $display("FAIL mid_rx: got %0d beats want 2 (51 on ch1, 66 on ch6)",
               rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    rx_q.delete();
    fork
      begin
        bit ok;
        for (int k = 0; k < 16; k++) begin
          send(3'd0, 8'h80 + 8'(k), (k == 15), ok);
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL b2b_accept[%0d]: got timeout want accepted", k);
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 400 && !done; c++) begin
          @(posedge clk);
          #1;
          out_ready[0] = ~out_ready[0];
        end
      end
    join
    out_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_q.size() != 16) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 16", rx_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (rx_q[k] !== {4'd0, (k == 15), 8'h80 + 8'(k)}) begin
          errors++;
          $display("FAIL b2b_rx[%0d]: got %h want %h", k, rx_q[k],
                   {4'd0, (k == 15), 8'h80 + 8'(k)});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beats();
    test_packet_lock();
    test_stall();
    test_drop();
    test_reset_mid_packet();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demux1_n_stream
